// File: rtl/cond_eval_unit.sv
// -----------------------------------------------------------------------------
// cond_eval_unit
//
// Consumer end of the ALU flag interface in the execute stage.
//   * Captures the ALU's Z/C/N/V flags into an architectural status register.
//     Each micro-op has a write mask. SUB/CMP can optionally invert the carry,
//     which turns the ALU borrow into an ARM-style carry.
//   * Evaluates ARM 4-bit condition codes against those flags. Queries use a
//     valid/ready request and a valid/ready response with a one-entry
//     response buffer.
//
// Configuration macro: COND_FLAG_FWD_EN
//   defined   : a query in the same cycle as a flag write sees the new flags
//               (the write is forwarded). Queries never stall.
//   undefined : queries see only the registered flags. A query that arrives
//               in the same cycle as a flag write is held off for one cycle,
//               so it is evaluated against the updated register.
//
// Parameters:
//   SUB_CARRY_INVERT  1: stored C = ~ALU carry for SUB/CMP; 0: stored as-is
//   UOP_W             width of alu_uop
//
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   flag_we     instruction in execute sets flags this cycle
//   alu_uop     ALU micro-op of that instruction (selects the write mask)
//   alu_flags   [0]=Z [1]=C [2]=N [3]=V from the ALU
//   req_valid   condition query present
//   req_cond    ARM condition code of the query
//   req_ready   query accepted when req_valid && req_ready
//   resp_valid  response present
//   resp_ready  response consumed when resp_valid && resp_ready
//   resp_taken  condition passed
//   resp_undef  query used the reserved code 4'b1111
//   flags_q     architectural flags, same bit order as alu_flags
// -----------------------------------------------------------------------------
module cond_eval_unit #(
    parameter bit SUB_CARRY_INVERT = 1'b1,
    parameter int UOP_W            = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flag_we,
    input  logic [UOP_W-1:0] alu_uop,
    input  logic [0:3]       alu_flags,
    input  logic             req_valid,
    input  logic [3:0]       req_cond,
    output logic             req_ready,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_taken,
    output logic             resp_undef,
    output logic [0:3]       flags_q
);

    // Micro-op encodings that touch the flags.
    localparam logic [UOP_W-1:0] UOP_ADD = UOP_W'(1);
    localparam logic [UOP_W-1:0] UOP_SUB = UOP_W'(2);
    localparam logic [UOP_W-1:0] UOP_AND = UOP_W'(3);
    localparam logic [UOP_W-1:0] UOP_XOR = UOP_W'(4);
    localparam logic [UOP_W-1:0] UOP_CMP = UOP_W'(5);
    localparam logic [UOP_W-1:0] UOP_LSL = UOP_W'(6);
    localparam logic [UOP_W-1:0] UOP_LSR = UOP_W'(7);
    localparam logic [UOP_W-1:0] UOP_MOV = UOP_W'(8);

    // Bit positions within the [0:3] flag vectors.
    localparam int FZ = 0;
    localparam int FC = 1;
    localparam int FN = 2;
    localparam int FV = 3;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t     state;
    logic [0:3] flags_next;   // value flags_q takes at the coming edge
    logic [0:3] flags_eff;    // flags the condition is evaluated against
    logic       stall;
    logic       accept;
    logic [1:0] eval_res;     // {taken, undef}

    // -------------------------------------------------------------------------
    // Condition evaluation: returns {taken, undef}.
    // -------------------------------------------------------------------------
    function automatic logic [1:0] eval_cond(input logic [3:0] cond,
                                             input logic [0:3] f);
        logic z, c, n, v;
        logic taken;
        logic undef;
        z     = f[FZ];
        c     = f[FC];
        n     = f[FN];
        v     = f[FV];
        undef = 1'b0;
        case (cond)
            4'b0000: taken = z;                  // EQ
            4'b0001: taken = ~z;                 // NE
            4'b0010: taken = c;                  // CS
            4'b0011: taken = ~c;                 // CC
            4'b0100: taken = n;                  // MI
            4'b0101: taken = ~n;                 // PL
            4'b0110: taken = v;                  // VS
            4'b0111: taken = ~v;                 // VC
            4'b1000: taken = c & ~z;             // HI
            4'b1001: taken = ~c | z;             // LS
            4'b1010: taken = (n == v);           // GE
            4'b1011: taken = (n != v);           // LT
            4'b1100: taken = ~z & (n == v);      // GT
            4'b1101: taken = z | (n != v);       // LE
            4'b1110: taken = 1'b1;               // AL
            default: begin                       // 1111: reserved
                taken = 1'b0;
                undef = 1'b1;
            end
        endcase
        return {taken, undef};
    endfunction

    // -------------------------------------------------------------------------
    // Masked flag update. Fields that a micro-op does not write keep their
    // current value.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: assign every always_comb output a default before any branch;
        // a path that leaves it unassigned would infer a latch.
        flags_next = flags_q;
        if (flag_we) begin
            case (alu_uop)
                UOP_ADD: flags_next = alu_flags;
                UOP_SUB, UOP_CMP: begin
                    flags_next[FZ] = alu_flags[FZ];
                    flags_next[FN] = alu_flags[FN];
                    flags_next[FV] = alu_flags[FV];
                    // ALU reports a borrow; the ARM convention is carry = ~borrow.
                    flags_next[FC] = SUB_CARRY_INVERT ? ~alu_flags[FC]
                                                      : alu_flags[FC];
                end
                UOP_LSL: begin
                    flags_next[FZ] = alu_flags[FZ];
                    flags_next[FC] = alu_flags[FC];
                    flags_next[FN] = alu_flags[FN];
                end
                UOP_AND, UOP_XOR, UOP_LSR, UOP_MOV: begin
                    flags_next[FZ] = alu_flags[FZ];
                    flags_next[FN] = alu_flags[FN];
                end
                default: ;  // uop does not affect flags
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Flag source for evaluation and the matching hazard stall.
    // -------------------------------------------------------------------------
`ifdef COND_FLAG_FWD_EN
    assign flags_eff = flags_next;
    assign stall     = 1'b0;
`else
    assign flags_eff = flags_q;
    // Hold off a query that collides with a flag write. The query is then
    // evaluated next cycle against the freshly written register.
    assign stall     = flag_we & req_valid;
`endif

    // The buffer can take a new query when it is empty or is draining this
    // cycle.
    assign req_ready = ((state == IDLE) | resp_ready) & ~stall;
    assign accept    = req_valid & req_ready;
    assign eval_res  = eval_cond(req_cond, flags_eff);

    // -------------------------------------------------------------------------
    // Flag register and response buffer. Flag writes proceed regardless of
    // response backpressure. A buffered response is never re-evaluated.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignment so every register
        // samples the pre-edge values, whatever the statement order.
        if (!rst_n) begin
            flags_q    <= '0;
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_taken <= 1'b0;
            resp_undef <= 1'b0;
        end else begin
            flags_q <= flags_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state                    <= RESP;
                        resp_valid               <= 1'b1;
                        {resp_taken, resp_undef} <= eval_res;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        if (accept) begin
                            // Back-to-back: replace the consumed response.
                            {resp_taken, resp_undef} <= eval_res;
                        end else begin
                            state      <= IDLE;
                            resp_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
